stopwatch_ctrl: RTL and testbench

Controller that sequences a chain of modulo digit counters to form an MM:SS stopwatch.
- A prescaler turns the system clock into a one-second enable tick.
- A 4-state FSM handles start/stop, lap-freeze and clear commands from debounced, single-cycle button pulses.
- Sits between the upstream button edge-detectors and the 7-segment decoders on the board top level.

---
 rtl/stopwatch_pkg.sv | 24 ++
 rtl/digit_counter.sv | 29 ++
 rtl/stopwatch_ctrl.sv | 121 ++++++++++++
 tb/tb_stopwatch_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared state encoding, digit limits and display bundle for the MM:SS stopwatch.
// No logic; types and constants only.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    LAP    = 2'd3
  } state_t;

  localparam int SEC_ONES_MAX = 9;
  localparam int SEC_TENS_MAX = 5;
  localparam int MIN_ONES_MAX = 9;
  localparam int MIN_TENS_MAX = 5;

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
  } digits_t;

endpackage

// File: rtl/digit_counter.sv
// Modulo-K counter stage; Q updates one cycle after En, Wrap is same-cycle combinational.
// No backpressure: En is a one-cycle advance strobe, Clr wins over En.
module digit_counter #(
  parameter int N = 4,
  parameter int K = 10
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         En,
  input  logic         Clr,
  output logic [N-1:0] Q,
  output logic         Wrap
);

  localparam logic [N-1:0] LAST = N'(K - 1);

  assign Wrap = En && (Q == LAST);

  always_ff @(posedge Clock) begin
    if (Reset || Clr) begin
      Q <= '0;
    end else if (Wrap) begin
      Q <= '0;
    end else if (En) begin
      Q <= Q + N'(1);
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch: prescaler, four chained BCD digit stages and a run/pause/lap/clear FSM.
// Commands take effect next cycle; display is a registered mux, no input-to-output path.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 50000000,
  parameter int DIV_W    = 26
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start_Stop,
  input  logic       Lap,
  input  logic       Clear,
  output logic [3:0] Sec_ones,
  output logic [3:0] Sec_tens,
  output logic [3:0] Min_ones,
  output logic [3:0] Min_tens,
  output logic       Running,
  output logic       Lap_hold,
  output logic       Overflow
);

  localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(TICK_DIV - 1);

  state_t           state, state_nxt;
  logic [DIV_W-1:0] presc;
  logic             cnt_en;
  logic             tick;
  logic             so_wrap, st_wrap, mo_wrap, mt_wrap;
  logic             lap_latch;
  digits_t          live, lap_dig, disp;

  // A command pulse never gates its own cycle: enable comes from the current state only.
  assign cnt_en = (state == RUN) || (state == LAP);
  assign tick   = cnt_en && (presc == TICK_LAST);

  always_ff @(posedge Clock) begin
    if (Reset || Clear) begin
      presc <= '0;
    end else if (cnt_en) begin
      presc <= tick ? '0 : presc + DIV_W'(1);
    end
  end

  digit_counter #(.N(4), .K(SEC_ONES_MAX + 1)) u_sec_ones (
    .Clock(Clock), .Reset(Reset), .En(tick), .Clr(Clear),
    .Q(live.sec_ones), .Wrap(so_wrap)
  );

  digit_counter #(.N(4), .K(SEC_TENS_MAX + 1)) u_sec_tens (
    .Clock(Clock), .Reset(Reset), .En(so_wrap), .Clr(Clear),
    .Q(live.sec_tens), .Wrap(st_wrap)
  );

  digit_counter #(.N(4), .K(MIN_ONES_MAX + 1)) u_min_ones (
    .Clock(Clock), .Reset(Reset), .En(st_wrap), .Clr(Clear),
    .Q(live.min_ones), .Wrap(mo_wrap)
  );

  digit_counter #(.N(4), .K(MIN_TENS_MAX + 1)) u_min_tens (
    .Clock(Clock), .Reset(Reset), .En(mo_wrap), .Clr(Clear),
    .Q(live.min_tens), .Wrap(mt_wrap)
  );

  always_ff @(posedge Clock) begin
    if (Reset || Clear) begin
      Overflow <= 1'b0;
    end else if (mt_wrap) begin
      Overflow <= 1'b1;
    end
  end

  // Lap only acts when no higher-priority command shares the cycle.
  assign lap_latch = (state == RUN) && Lap && !Clear && !Start_Stop;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      lap_dig <= '0;
    end else if (lap_latch) begin
      lap_dig <= live;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (Clear) begin
      state_nxt = IDLE;
    end else if (Start_Stop) begin
      case (state)
        IDLE:    state_nxt = RUN;
        RUN:     state_nxt = PAUSED;
        LAP:     state_nxt = PAUSED;
        PAUSED:  state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end else if (Lap) begin
      case (state)
        RUN:     state_nxt = LAP;
        LAP:     state_nxt = RUN;
        default: state_nxt = state;
      endcase
    end
  end

  assign disp     = (state == LAP) ? lap_dig : live;
  assign Sec_ones = disp.sec_ones;
  assign Sec_tens = disp.sec_tens;
  assign Min_ones = disp.min_ones;
  assign Min_tens = disp.min_tens;
  assign Running  = cnt_en;
  assign Lap_hold = (state == LAP);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: two instances (TICK_DIV 4 and 2) share stimulus and are
// compared every cycle against an elapsed-seconds model, plus literal spot checks.
module tb_stopwatch_ctrl;

  logic Clock = 1'b0;
  logic Reset, Start_Stop, Lap, Clear;

  logic [3:0] a_so, a_st, a_mo, a_mt;
  logic       a_run, a_lh, a_ovf;
  logic [3:0] b_so, b_st, b_mo, b_mt;
  logic       b_run, b_lh, b_ovf;

  always #5 Clock = ~Clock;

  stopwatch_ctrl #(.TICK_DIV(4), .DIV_W(3)) dut_a (
    .Clock(Clock), .Reset(Reset), .Start_Stop(Start_Stop), .Lap(Lap), .Clear(Clear),
    .Sec_ones(a_so), .Sec_tens(a_st), .Min_ones(a_mo), .Min_tens(a_mt),
    .Running(a_run), .Lap_hold(a_lh), .Overflow(a_ovf)
  );

  stopwatch_ctrl #(.TICK_DIV(2), .DIV_W(2)) dut_b (
    .Clock(Clock), .Reset(Reset), .Start_Stop(Start_Stop), .Lap(Lap), .Clear(Clear),
    .Sec_ones(b_so), .Sec_tens(b_st), .Min_ones(b_mo), .Min_tens(b_mt),
    .Running(b_run), .Lap_hold(b_lh), .Overflow(b_ovf)
  );

  logic [15:0] disp_a, disp_b;
  assign disp_a = {a_mt, a_mo, a_st, a_so};
  assign disp_b = {b_mt, b_mo, b_st, b_so};

  // Model: whole elapsed seconds plus clock cycles into the current second.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3;
  int m_div  [2] = '{4, 2};
  int m_secs [2] = '{0, 0};
  int m_frac [2] = '{0, 0};
  int m_lap  [2] = '{0, 0};
  int m_mode [2] = '{M_IDLE, M_IDLE};
  bit m_ovf  [2] = '{1'b0, 1'b0};

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_step(input int i, input bit r, input bit c, input bit s, input bit l);
    int  old;
    bit  active;
    if (r) begin
      m_secs[i] = 0; m_frac[i] = 0; m_lap[i] = 0; m_mode[i] = M_IDLE; m_ovf[i] = 1'b0;
    end else if (c) begin
      m_secs[i] = 0; m_frac[i] = 0; m_mode[i] = M_IDLE; m_ovf[i] = 1'b0;
    end else begin
      old    = m_secs[i];
      active = (m_mode[i] == M_RUN) || (m_mode[i] == M_LAP);
      if (active) begin
        m_frac[i]++;
        if (m_frac[i] == m_div[i]) begin
          m_frac[i] = 0;
          m_secs[i] = (m_secs[i] + 1) % 3600;
          if (m_secs[i] == 0) m_ovf[i] = 1'b1;
        end
      end
      if (s) begin
        m_mode[i] = active ? M_PAUSE : M_RUN;
      end else if (l) begin
        if (m_mode[i] == M_RUN) begin
          m_mode[i] = M_LAP;
          m_lap[i]  = old;
        end else if (m_mode[i] == M_LAP) begin
          m_mode[i] = M_RUN;
        end
      end
    end
  endtask

  function automatic logic [18:0] expect_vec(input int i);
    int s;
    s = (m_mode[i] == M_LAP) ? m_lap[i] : m_secs[i];
    return {4'(s / 600), 4'((s / 60) % 10), 4'((s / 10) % 6), 4'(s % 10),
            (m_mode[i] == M_RUN) || (m_mode[i] == M_LAP), m_mode[i] == M_LAP, m_ovf[i]};
  endfunction

  function automatic logic [18:0] dut_vec(input int i);
    if (i == 0) return {disp_a, a_run, a_lh, a_ovf};
    return {disp_b, b_run, b_lh, b_ovf};
  endfunction

  // One clock: drive inputs, advance the model on the edge, compare both instances after it.
  task automatic step(input bit r, input bit c, input bit s, input bit l);
    Reset = r; Clear = c; Start_Stop = s; Lap = l;
    @(posedge Clock);
    for (int i = 0; i < 2; i++) model_step(i, r, c, s, l);
    #1;
    check("cycle_div4", 32'(dut_vec(0)), 32'(expect_vec(0)));
    check("cycle_div2", 32'(dut_vec(1)), 32'(expect_vec(1)));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    Reset = 1'b0; Clear = 1'b0; Start_Stop = 1'b0; Lap = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("reset_a", 32'({disp_a, a_run, a_lh, a_ovf}), 32'd0);
    check("reset_b", 32'({disp_b, b_run, b_lh, b_ovf}), 32'd0);

    // Start latency with TICK_DIV=4
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("start_running", 32'(a_run), 32'd1);
    idle(3);
    check("before_first_tick", 32'(a_so), 32'd0);
    idle(1);
    check("first_tick", 32'(a_so), 32'd1);
    idle(4);
    check("second_tick", 32'(a_so), 32'd2);

    // Pause keeps display and fractional second
    idle(4);
    check("at_0003", 32'(disp_a), 32'h0003);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(20);
    check("paused_disp", 32'(disp_a), 32'h0003);
    check("paused_running", 32'(a_run), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    check("resume_early", 32'(a_so), 32'd3);
    idle(1);
    check("resume_tick", 32'(a_so), 32'd4);

    // Lap freeze with TICK_DIV=2
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(10);
    check("lap_pre", 32'(disp_b), 32'h0005);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("lap_hold_on", 32'(b_lh), 32'd1);
    idle(8);
    check("lap_frozen", 32'(disp_b), 32'h0005);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("lap_release_disp", 32'(disp_b), 32'h0010);
    check("lap_hold_off", 32'(b_lh), 32'd0);

    // Full-hour wrap with TICK_DIV=2
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(7198);
    check("at_5959", 32'(disp_b), 32'h5959);
    check("no_ovf_yet", 32'(b_ovf), 32'd0);
    idle(2);
    check("wrap_disp", 32'(disp_b), 32'h0000);
    check("wrap_ovf", 32'(b_ovf), 32'd1);
    check("wrap_running", 32'(b_run), 32'd1);

    // Clear beats Start_Stop in the same cycle
    idle(166);
    check("at_0123", 32'(disp_b), 32'h0123);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("clear_disp", 32'(disp_b), 32'h0000);
    check("clear_running", 32'(b_run), 32'd0);
    check("clear_ovf", 32'(b_ovf), 32'd0);

    // Reset in LAP, then Lap is ignored in IDLE
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(5);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);
    check("in_lap", 32'({a_lh, b_lh}), 32'd3);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("reset_in_lap_a", 32'({disp_a, a_run, a_lh, a_ovf}), 32'd0);
    check("reset_in_lap_b", 32'({disp_b, b_run, b_lh, b_ovf}), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("idle_lap_ignored", 32'({disp_b, b_run, b_lh, b_ovf}), 32'd0);

    // Random command pulses
    for (int n = 0; n < 4000; n++) begin
      step($urandom_range(0, 499) == 0, $urandom_range(0, 199) == 0,
           $urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0);
    end
    Reset = 1'b0; Clear = 1'b0; Start_Stop = 1'b0; Lap = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
